segasys1_sndlatch: RTL
======================

# segasys1_sndlatch

Sound command mailbox between the main CPU and the sound CPU. It captures the one-cycle `SNDRQ`/`SNDNO` pulse from the main CPU block into a small FIFO, and presents the head byte on the sound CPU's latch port. It drives the sound CPU NMI so that every queued command produces its own NMI edge. It also generates the sound CPU's periodic maskable interrupt.

## Interface
Parameters:
- `DEPTH_LOG2`, 2: FIFO holds 2^DEPTH_LOG2 = 4 commands.
- `NMI_GAP`, 16: CLK48M cycles that `SNMI` is held low between consecutive commands.
- `IRQ_DIV`, 200000: CLK48M cycles per `SIRQ` period (4 per 60 Hz frame).

Ports (reset is RESET, asynchronous, active-high; clock is CLK48M):
- `CLK48M`  in  1  system clock; all state on its rising edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `SNDRQ`  in  1  one-cycle push strobe from the main CPU block.
- `SNDNO`  in  8  command byte, valid while `SNDRQ` is high.
- `SRDSEL`  in  1  sound CPU latch read select (mreq & rd & address decode), level, many cycles long.
- `SIACK`  in  1  sound CPU interrupt acknowledge (m1 & iorq), level.
- `LATCH_DO`  out  8  byte returned to the sound CPU data selector.
- `SNMI`  out  1  NMI request to the sound CPU, active-high.
- `SIRQ`  out  1  maskable IRQ request to the sound CPU, active-high.
- `FULL`  out  1  FIFO holds 2^DEPTH_LOG2 entries.
- `OVF`  out  1  sticky: a push was dropped because the FIFO was full.

## Operation
- FIFO: write pointer, read pointer (DEPTH_LOG2 bits each, wrap modulo depth), count (DEPTH_LOG2+1 bits).
- Push: on `SNDRQ`=1.
  - If not full: store `SNDNO` at the write pointer and advance it.
  - If full: drop the byte and set `OVF`.
- Pop: on the cycle after `SRDSEL` falls, detected with a registered 1→0 edge. The pop is at end of access, so `LATCH_DO` stays stable for the whole read.
  - Pop copies the head byte into the `last` register and advances the read pointer.
  - Pop when empty does nothing.
- Simultaneous push and pop in one cycle: both are performed and count is unchanged. When the FIFO is full, the simultaneous push is accepted, not dropped.
- `LATCH_DO`: head entry when non-empty, else `last`. Reset value of `last` is 8'h00.
- NMI FSM has three states:
  - IDLE (`SNMI`=0): go to ASSERT when count≠0.
  - ASSERT (`SNMI`=1): on pop, go to GAP and load the gap counter with NMI_GAP-1.
  - GAP (`SNMI`=0): count down to 0, then go to ASSERT if count≠0, else IDLE.
  - A push arriving during GAP does not shorten the gap.
- IRQ timer: an 18-bit counter runs 0..IRQ_DIV-1 and wraps to 0.
  - At wrap, set `SIRQ`.
  - Clear `SIRQ` on the registered rising edge of `SIACK`.
  - If set and clear occur in the same cycle, set wins.
  - The timer runs continuously and is not gated by `SIRQ`.
- Reset mid-operation:
  - FIFO is emptied, pointers go to 0, and `last`=0.
  - FSM goes to IDLE, and `SNMI`, `SIRQ`, `OVF` are all 0.
  - The IRQ counter is cleared to 0.

## Timing
- Push latency: `SNDRQ` high at edge N makes the FIFO non-empty after edge N and `LATCH_DO` valid in cycle N+1. `SNMI` rises after edge N+1 (FSM is registered).
- Pop latency: `SRDSEL` low sampled at edge N, with the edge detected at N, makes the pointer advance at N+1. `LATCH_DO` changes after N+1, and `SNMI` falls after N+1.
- Consecutive NMIs: `SNMI` low time is exactly NMI_GAP cycles after each pop when more commands are queued.
- `SIRQ`: first assertion is IRQ_DIV cycles after reset release, then every IRQ_DIV cycles.
- `FULL` and `OVF` are registered; `OVF` sets one cycle after the dropped push.

## Test plan
- Single command: push 8'h5A, then idle 10 cycles → `SNMI`=1 and `LATCH_DO`=8'h5A. Then run a 40-cycle `SRDSEL` pulse → `LATCH_DO`=8'h5A throughout, `SNMI`=0 after release, and `LATCH_DO` holds 8'h5A while empty.
- Queue of 3: push 01, 02, 03 back-to-back, then service each on NMI → reads return 01, 02, 03 in order, and `SNMI` is low for exactly 16 cycles between them.
- Overflow: push 5 bytes with no reads → `FULL`=1 after the 4th, `OVF`=1 after the 5th, and reads return the first 4 bytes only.
- Simultaneous push and pop with FIFO full → byte accepted, count stays 4, `OVF` stays 0.
- IRQ: with IRQ_DIV=100, `SIRQ` rises at cycle 100; `SIACK` at cycle 130 → `SIRQ` low at 131 and high again at 200. `SIACK` coinciding with a wrap → `SIRQ` stays 1.
- Reset mid-queue: 2 entries pending, `SNMI`=1, `SIRQ`=1, then assert `RESET` → all outputs 0, `LATCH_DO`=8'h00, and the next `SIRQ` comes IRQ_DIV cycles after release.

Source files
------------

// File: rtl/segasys1_sndlatch_if.sv
// Main-CPU / sound-CPU side signals of the sound command mailbox.
// master: the CPU side (drives commands, reads, acks); slave: the mailbox.
interface segasys1_sndlatch_if;
   logic       SNDRQ;
   logic [7:0] SNDNO;
   logic       SRDSEL;
   logic       SIACK;
   logic [7:0] LATCH_DO;
   logic       SNMI;
   logic       SIRQ;
   logic       FULL;
   logic       OVF;

   modport master (
      output SNDRQ, SNDNO, SRDSEL, SIACK,
      input  LATCH_DO, SNMI, SIRQ, FULL, OVF
   );

   modport slave (
      input  SNDRQ, SNDNO, SRDSEL, SIACK,
      output LATCH_DO, SNMI, SIRQ, FULL, OVF
   );
endinterface

// File: rtl/segasys1_sndlatch.sv
// Sound command mailbox: small FIFO from main CPU to sound CPU, one NMI per
// queued command with a fixed low gap between them, plus the periodic IRQ.
//
// NMI FSM
//   state    | meaning
//   S_IDLE   | nothing queued, SNMI low
//   S_ASSERT | head command waiting for the sound CPU, SNMI high
//   S_GAP    | command just consumed, SNMI held low for NMI_GAP cycles
module segasys1_sndlatch #(
   parameter int DEPTH_LOG2 = 2,
   parameter int NMI_GAP    = 16,
   parameter int IRQ_DIV    = 200000
) (
   input  logic               CLK48M,
   input  logic               RESET,
   segasys1_sndlatch_if.slave bus
);
   localparam int                  DEPTH      = 1 << DEPTH_LOG2;
   localparam int                  GW         = (NMI_GAP > 2) ? $clog2(NMI_GAP) : 1;
   localparam logic [DEPTH_LOG2:0] C_FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] C_CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2-1:0] C_PTR_ONE = DEPTH_LOG2'(1);
   localparam logic [GW-1:0]       C_GAP_LOAD = GW'(NMI_GAP - 1);
   localparam logic [GW-1:0]       C_GAP_ONE  = GW'(1);
   localparam logic [17:0]         C_IRQ_LAST = 18'(IRQ_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ASSERT = 2'd1,
      S_GAP    = 2'd2
   } nmi_state_t;

   logic [7:0]            r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_count;
   logic [7:0]            r_last;
   logic                  r_full;
   logic                  r_ovf;
   logic                  r_srdsel_q;
   logic                  r_pop_req;
   logic                  r_siack_q;
   logic                  r_ack_req;
   logic [17:0]           r_irq_cnt;
   logic                  r_sirq;
   logic [GW-1:0]         r_gap_cnt;
   nmi_state_t            r_state;

   logic                  w_empty;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_drop;
   logic [DEPTH_LOG2:0]   w_count_nxt;
   logic                  w_irq_wrap;
   nmi_state_t            w_state_nxt;
   logic                  w_gap_load;
   logic                  w_gap_dec;
   logic                  w_snmi;

   // A pop frees a slot in the same cycle, so a push while full still fits.
   assign w_empty    = (r_count == '0);
   assign w_pop      = r_pop_req & ~w_empty;
   assign w_push     = bus.SNDRQ & (~r_full | w_pop);
   assign w_drop     = bus.SNDRQ & r_full & ~w_pop;
   assign w_irq_wrap = (r_irq_cnt == C_IRQ_LAST);

   // Occupancy after this cycle's push/pop.
   always_comb begin
      w_count_nxt = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + C_CNT_ONE;
         2'b01:   w_count_nxt = r_count - C_CNT_ONE;
         default: w_count_nxt = r_count;
      endcase
   end

   // Command storage; contents need no reset since occupancy gates every read.
   always_ff @(posedge CLK48M) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= bus.SNDNO;
      end
   end

   // Pointers, count, flags and the end-of-read pop request.
   always_ff @(posedge CLK48M or posedge RESET) begin
      if (RESET) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_last     <= 8'h00;
         r_full     <= 1'b0;
         r_ovf      <= 1'b0;
         r_srdsel_q <= 1'b0;
         r_pop_req  <= 1'b0;
      end else begin
         r_srdsel_q <= bus.SRDSEL;
         r_pop_req  <= r_srdsel_q & ~bus.SRDSEL;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            r_last   <= r_mem[r_rd_ptr];
         end
         if (w_drop) begin
            r_ovf <= 1'b1;
         end
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == C_FULL_CNT);
      end
   end

   // NMI state register and gap timer.
   always_ff @(posedge CLK48M or posedge RESET) begin
      if (RESET) begin
         r_state   <= S_IDLE;
         r_gap_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_gap_load) begin
            r_gap_cnt <= C_GAP_LOAD;
         end else if (w_gap_dec) begin
            r_gap_cnt <= r_gap_cnt - C_GAP_ONE;
         end
      end
   end

   // NMI next state; the gap always runs to completion regardless of pushes.
   always_comb begin
      w_state_nxt = r_state;
      w_gap_load  = 1'b0;
      w_gap_dec   = 1'b0;
      w_snmi      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty) begin
               w_state_nxt = S_ASSERT;
            end
         end
         S_ASSERT: begin
            w_snmi = 1'b1;
            if (w_pop) begin
               w_state_nxt = S_GAP;
               w_gap_load  = 1'b1;
            end
         end
         S_GAP: begin
            if (r_gap_cnt == '0) begin
               w_state_nxt = w_empty ? S_IDLE : S_ASSERT;
            end else begin
               w_gap_dec = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Free-running IRQ divider; SIRQ set on wrap, cleared on ack, set wins.
   always_ff @(posedge CLK48M or posedge RESET) begin
      if (RESET) begin
         r_irq_cnt <= '0;
         r_sirq    <= 1'b0;
         r_siack_q <= 1'b0;
         r_ack_req <= 1'b0;
      end else begin
         r_siack_q <= bus.SIACK;
         r_ack_req <= bus.SIACK & ~r_siack_q;
         if (w_irq_wrap) begin
            r_irq_cnt <= '0;
         end else begin
            r_irq_cnt <= r_irq_cnt + 18'd1;
         end
         if (w_irq_wrap) begin
            r_sirq <= 1'b1;
         end else if (r_ack_req) begin
            r_sirq <= 1'b0;
         end
      end
   end

   assign bus.LATCH_DO = w_empty ? r_last : r_mem[r_rd_ptr];
   assign bus.SNMI     = w_snmi;
   assign bus.SIRQ     = r_sirq;
   assign bus.FULL     = r_full;
   assign bus.OVF      = r_ovf;
endmodule
